// File: rtl/lif_neuron_if.sv
// rtl/lif_neuron_if.sv - weight/tick inputs and spike/state outputs of the lif neuron
interface lif_neuron_if #(
  parameter int VMEM_W = 16,
  parameter int TS_W   = 8
);
  logic              kill;
  logic              w_valid;
  logic [7:0]        w_data;
  logic              tick;
  logic              spike_out;
  logic [VMEM_W-1:0] vmem;
  logic              refrac_busy;
  logic [7:0]        spike_cnt;
  logic [TS_W-1:0]   t_now;
  logic [TS_W-1:0]   t_last_spike;

  modport master (
    output kill, w_valid, w_data, tick,
    input  spike_out, vmem, refrac_busy, spike_cnt, t_now, t_last_spike
  );

  modport slave (
    input  kill, w_valid, w_data, tick,
    output spike_out, vmem, refrac_busy, spike_cnt, t_now, t_last_spike
  );
endinterface

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - leaky integrate-and-fire neuron with refractory hold-off
module lif_neuron #(
  parameter int VMEM_W     = 16,
  parameter int THRESH     = 100,
  parameter int V_RESET    = 0,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2,
  parameter int TS_W       = 8
) (
  input logic        clk,
  input logic        rst,
  lif_neuron_if.slave nif
);
  localparam int RC_W = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);

  typedef enum logic {ST_INTEG, ST_REFRAC} state_t;

  state_t            state;
  logic [RC_W-1:0]   rcnt;
  logic [VMEM_W-1:0] vmem_q;
  logic              spike_q;
  logic              busy_q;
  logic [7:0]        cnt_q;
  logic [TS_W-1:0]   t_now_q;
  logic [TS_W-1:0]   t_last_q;

  logic [VMEM_W+1:0] sum;
  logic [VMEM_W-1:0] v1;
  logic [VMEM_W-1:0] v2;
  logic              fire;

  // Two guard bits: bit VMEM_W+1 flags a negative result, bit VMEM_W an overflow.
  always_comb begin
    sum  = {2'b00, vmem_q}
         + (nif.w_valid ? {{(VMEM_W-6){nif.w_data[7]}}, nif.w_data} : '0);
    if (sum[VMEM_W+1])
      v1 = '0;
    else if (sum[VMEM_W])
      v1 = '1;
    else
      v1 = sum[VMEM_W-1:0];
    v2   = nif.tick ? (v1 - (v1 >> LEAK_SHIFT)) : v1;
    fire = nif.tick && (state == ST_INTEG) && (v2 >= VMEM_W'(THRESH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INTEG;
      rcnt     <= '0;
      vmem_q   <= '0;
      spike_q  <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      t_now_q  <= '0;
      t_last_q <= '0;
    end else if (nif.kill) begin
      state   <= ST_INTEG;
      rcnt    <= '0;
      vmem_q  <= VMEM_W'(V_RESET);
      spike_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      spike_q <= 1'b0;
      if (nif.tick)
        t_now_q <= t_now_q + TS_W'(1);
      case (state)
        ST_INTEG: begin
          if (fire) begin
            spike_q  <= 1'b1;
            vmem_q   <= VMEM_W'(V_RESET);
            cnt_q    <= cnt_q + 8'd1;
            t_last_q <= t_now_q + TS_W'(1);
            if (REFRAC > 0) begin
              state  <= ST_REFRAC;
              rcnt   <= RC_W'(REFRAC);
              busy_q <= 1'b1;
            end
          end else begin
            vmem_q <= v2;
          end
        end
        ST_REFRAC: begin
          // Weights are dropped here; only ticks advance the hold-off.
          vmem_q <= VMEM_W'(V_RESET);
          if (nif.tick) begin
            rcnt <= rcnt - RC_W'(1);
            if (rcnt == RC_W'(1)) begin
              state  <= ST_INTEG;
              busy_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign nif.spike_out    = spike_q;
  assign nif.vmem         = vmem_q;
  assign nif.refrac_busy  = busy_q;
  assign nif.spike_cnt    = cnt_q;
  assign nif.t_now        = t_now_q;
  assign nif.t_last_spike = t_last_q;
endmodule
